// File: rtl/cotm32_mu_seq_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package cotm32_mu_seq_pkg;

  localparam int XLEN     = 32;
  localparam int MU_ITERS = XLEN;

  typedef enum logic [3:0] {
    MU_NOP,
    MU_MUL,
    MU_MULH,
    MU_MULHSU,
    MU_MULHU,
    MU_DIV,
    MU_DIVU,
    MU_REM,
    MU_REMU
  } mu_op_t;

  typedef enum logic [1:0] {
    MU_SEQ_IDLE,
    MU_SEQ_CALC,
    MU_SEQ_FIX,
    MU_SEQ_DONE
  } mu_seq_state_t;

  function automatic logic is_mu_div(mu_op_t op);
    return (op == MU_DIV) || (op == MU_DIVU) || (op == MU_REM) || (op == MU_REMU);
  endfunction

  function automatic logic is_mu_signed_a(mu_op_t op);
    return (op == MU_MUL) || (op == MU_MULH) || (op == MU_MULHSU) ||
           (op == MU_DIV) || (op == MU_REM);
  endfunction

  function automatic logic is_mu_signed_b(mu_op_t op);
    return (op == MU_MUL) || (op == MU_MULH) || (op == MU_DIV) || (op == MU_REM);
  endfunction

endpackage

// File: rtl/cotm32_mu_seq_if.sv
// Request/result bundle between the execute stage and the mul/div sequencer.
interface cotm32_mu_seq_if
  import cotm32_mu_seq_pkg::*;
#(
  parameter int WIDTH = XLEN
);
  logic             start_i;
  mu_op_t           op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  ready_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output ready_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/cotm32_mu_iter.sv
// One iteration of the unsigned mul/div datapath. {hi,lo} is the shared
// working register: product accumulator for multiply, {remainder,quotient}
// for divide. opnd is the multiplicand or the divisor.
module cotm32_mu_iter
  import cotm32_mu_seq_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // shift-add multiply step or restoring divide step
  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {hi_i, lo_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        hi_o = diff[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = rem_sh[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/cotm32_mu_seq.sv
// Iterative RV32M multiply/divide sequencer, one bit per cycle.
//
//   state        | meaning
//   MU_SEQ_IDLE  | ready; accepts start, resolves NOP/div-by-zero/overflow
//   MU_SEQ_CALC  | WIDTH unsigned iterations on magnitudes
//   MU_SEQ_FIX   | select word, apply sign, register result
//   MU_SEQ_DONE  | done pulse, back to idle
module cotm32_mu_seq
  import cotm32_mu_seq_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input logic            clk,
  input logic            rst_n,
  cotm32_mu_seq_if.slave mu
);

  localparam int              CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  mu_seq_state_t    state_q, state_d;
  mu_op_t           op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0]   hi_step, lo_step, abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic               neg_a, neg_b, div_zero, div_ovf, op_div;

  cotm32_mu_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div_i (is_mu_div(op_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (hi_step),
    .lo_o     (lo_step)
  );

  // next-state, operand capture and result fix-up
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;

    op_div   = is_mu_div(mu.op_i);
    neg_a    = is_mu_signed_a(mu.op_i) & mu.a_i[WIDTH-1];
    neg_b    = is_mu_signed_b(mu.op_i) & mu.b_i[WIDTH-1];
    abs_a    = neg_a ? -mu.a_i : mu.a_i;
    abs_b    = neg_b ? -mu.b_i : mu.b_i;
    div_zero = op_div && (mu.b_i == '0);
    div_ovf  = ((mu.op_i == MU_DIV) || (mu.op_i == MU_REM)) &&
               (mu.a_i == MIN_NEG) && (mu.b_i == '1);
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

    if (mu.flush_i) begin
      state_d = MU_SEQ_IDLE;
    end else begin
      case (state_q)
        MU_SEQ_IDLE: begin
          if (mu.start_i) begin
            if (mu.op_i == MU_NOP) begin
              result_d = '0;
              state_d  = MU_SEQ_DONE;
            end else if (div_zero) begin
              result_d = ((mu.op_i == MU_REM) || (mu.op_i == MU_REMU)) ? mu.a_i : '1;
              state_d  = MU_SEQ_DONE;
            end else if (div_ovf) begin
              result_d = (mu.op_i == MU_DIV) ? MIN_NEG : '0;
              state_d  = MU_SEQ_DONE;
            end else begin
              op_d    = mu.op_i;
              cnt_d   = '0;
              // remainder follows the dividend sign; everything else the xor
              neg_d   = (mu.op_i == MU_REM) ? neg_a : (neg_a ^ neg_b);
              hi_d    = '0;
              lo_d    = op_div ? abs_a : abs_b;
              opnd_d  = op_div ? abs_b : abs_a;
              state_d = MU_SEQ_CALC;
            end
          end
        end
        MU_SEQ_CALC: begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = MU_SEQ_FIX;
        end
        MU_SEQ_FIX: begin
          case (op_q)
            MU_MUL:                        result_d = prod_fix[WIDTH-1:0];
            MU_MULH, MU_MULHSU, MU_MULHU:  result_d = prod_fix[2*WIDTH-1:WIDTH];
            MU_DIV, MU_DIVU:               result_d = neg_q ? -lo_q : lo_q;
            MU_REM, MU_REMU:               result_d = neg_q ? -hi_q : hi_q;
            default:                       result_d = '0;
          endcase
          state_d = MU_SEQ_DONE;
        end
        default: state_d = MU_SEQ_IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MU_SEQ_IDLE;
      op_q     <= MU_NOP;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign mu.ready_o  = (state_q == MU_SEQ_IDLE);
  assign mu.busy_o   = (state_q == MU_SEQ_CALC) || (state_q == MU_SEQ_FIX);
  assign mu.done_o   = (state_q == MU_SEQ_DONE);
  assign mu.result_o = result_q;

endmodule

// File: tb/tb_cotm32_mu_seq.sv
// Scoreboard bench for the mul/div sequencer.
module tb_cotm32_mu_seq;
  import cotm32_mu_seq_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  cotm32_mu_seq_if #(.WIDTH(32)) mu_bus ();

  cotm32_mu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mu    (mu_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mu(mu_op_t op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MU_MUL:    begin p = sa * sb; return p[31:0];  end
      MU_MULH:   begin p = sa * sb; return p[63:32]; end
      MU_MULHSU: begin p = sa * ub; return p[63:32]; end
      MU_MULHU:  begin p = ua * ub; return p[63:32]; end
      MU_DIV:    begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      MU_DIVU:   begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      MU_REM:    begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      MU_REMU:   begin if (b == 0) return a;  p = ua % ub; return p[31:0]; end
      default:   return '0;
    endcase
  endfunction

  function automatic int ref_lat(mu_op_t op, logic [31:0] a, logic [31:0] b);
    if (op == MU_NOP) return 1;
    if (is_mu_div(op) && b == 0) return 1;
    if ((op == MU_DIV || op == MU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // present a request for one cycle, then scramble the inputs
  task automatic issue(input mu_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mu_bus.start_i = 1'b1;
    mu_bus.op_i    = op;
    mu_bus.a_i     = a;
    mu_bus.b_i     = b;
    @(posedge clk);
    #1;
    mu_bus.start_i = 1'b0;
    mu_bus.op_i    = MU_MULH;
    mu_bus.a_i     = $urandom;
    mu_bus.b_i     = $urandom;
  endtask

  // watch for done; optionally pulse a stray start at cycle N+inj
  task automatic wait_done(input int budget, input int inj, output int lat,
                           output int ready_bad, output int busy_bad);
    lat = -1; ready_bad = 0; busy_bad = 0;
    for (int j = 1; j <= budget; j++) begin
      @(negedge clk);
      if (j == inj) begin
        mu_bus.start_i = 1'b1;
        mu_bus.op_i    = MU_MUL;
        mu_bus.a_i     = 32'd3;
        mu_bus.b_i     = 32'd4;
      end
      if (j == inj + 1) mu_bus.start_i = 1'b0;
      if (mu_bus.done_o) begin
        lat = j;
        break;
      end
      if (mu_bus.ready_o) ready_bad++;
      if (!mu_bus.busy_o) busy_bad++;
    end
    mu_bus.start_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input mu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat_exp,
                        input int inj);
    exp_t e;
    int lat, rb, bb;
    sb.push_back('{tag: tag, res: res, lat: lat_exp});
    issue(op, a, b);
    wait_done(60, inj, lat, rb, bb);
    e = sb.pop_front();
    chk({e.tag, "_lat"}, lat, e.lat);
    chk({e.tag, "_res"}, mu_bus.result_o, e.res);
    chk({e.tag, "_ready_low"}, rb, 0);
    chk({e.tag, "_busy"}, bb, 0);
    @(negedge clk);
    chk({e.tag, "_pulse"}, mu_bus.done_o, 1'b0);
    chk({e.tag, "_idle"}, mu_bus.ready_o, 1'b1);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      if (mu_bus.done_o) n++;
    end
  endtask

  mu_op_t ops[9] = '{MU_NOP, MU_MUL, MU_MULH, MU_MULHSU, MU_MULHU,
                     MU_DIV, MU_DIVU, MU_REM, MU_REMU};

  initial begin
    int n;
    logic [31:0] ra, rbv;
    mu_op_t rop;

    mu_bus.start_i = 1'b0;
    mu_bus.flush_i = 1'b0;
    mu_bus.op_i    = MU_NOP;
    mu_bus.a_i     = '0;
    mu_bus.b_i     = '0;

    #3;
    chk("rst_ready",  mu_bus.ready_o,  1'b1);
    chk("rst_busy",   mu_bus.busy_o,   1'b0);
    chk("rst_done",   mu_bus.done_o,   1'b0);
    chk("rst_result", mu_bus.result_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7_m3",  MU_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulh_min",  MU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op("mulhu_max", MU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mulhsu_m1", MU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    run_op("div_by0",   MU_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 1, 0);
    run_op("rem_by0",   MU_REM,    32'd5,        32'd0,        32'd5,         1, 0);
    run_op("div_ovf",   MU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",   MU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 0);
    run_op("div_m7_2",  MU_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34, 0);
    run_op("rem_m7_2",  MU_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, 0);
    run_op("divu_100_7", MU_DIVU,  32'd100,      32'd7,        32'd14,        34, 0);
    run_op("remu_100_7", MU_REMU,  32'd100,      32'd7,        32'd2,         34, 0);

    // flush at N+10: back to idle at N+11, no done, result untouched
    issue(MU_DIVU, 32'd1000, 32'd3);
    for (int j = 1; j < 10; j++) @(negedge clk);
    @(negedge clk);
    mu_bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    mu_bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_ready", mu_bus.ready_o, 1'b1);
    chk("flush_done",  mu_bus.done_o,  1'b0);
    count_done(40, n);
    chk("flush_no_done", n, 0);
    chk("flush_result",  mu_bus.result_o, 32'd2);

    // stray start at N+5 while busy must be ignored
    run_op("divu_stray", MU_DIVU, 32'd100, 32'd7, 32'd14, 34, 5);

    // asynchronous reset mid-calc
    issue(MU_MUL, 32'd7, 32'hFFFF_FFFD);
    for (int j = 0; j < 10; j++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready",  mu_bus.ready_o,  1'b1);
    chk("arst_busy",   mu_bus.busy_o,   1'b0);
    chk("arst_done",   mu_bus.done_o,   1'b0);
    chk("arst_result", mu_bus.result_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, n);
    chk("arst_no_done", n, 0);

    run_op("divu_again", MU_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
    run_op("nop",        MU_NOP,  32'd9,   32'd9, 32'h0,   1, 0);

    for (int i = 0; i < 10; i++) begin
      rop = ops[$urandom_range(0, 8)];
      ra  = $urandom;
      rbv = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op($sformatf("rnd%0d", i), rop, ra, rbv, ref_mu(rop, ra, rbv),
             ref_lat(rop, ra, rbv), 0);
    end

    // flush beats a simultaneous start
    @(negedge clk);
    mu_bus.start_i = 1'b1;
    mu_bus.flush_i = 1'b1;
    mu_bus.op_i    = MU_NOP;
    @(posedge clk);
    #1;
    mu_bus.start_i = 1'b0;
    mu_bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_prio_ready", mu_bus.ready_o, 1'b1);
    chk("flush_prio_done",  mu_bus.done_o,  1'b0);

    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cotm32_mu_seq.md
Name: cotm32_mu_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide unit.
- Accepts one mu_op_t operation with two XLEN operands and runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Applies RISC-V sign and special-case rules, then returns a single result with a done pulse.
- Sits beside the ALU in execute; the core stalls on busy_o and writes back through REG_WB_MU.

Parameters:
- WIDTH, default XLEN (32): operand/result width and iteration count.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  request valid; sampled only when ready_o=1
- op_i  in  mu_op_t  operation; captured on accepted start
- a_i  in  WIDTH  rs1 operand (multiplicand/dividend)
- b_i  in  WIDTH  rs2 operand (multiplier/divisor)
- flush_i  in  1  abort current operation (trap/redirect)
- ready_o  out  1  state==IDLE
- busy_o  out  1  state in {CALC, FIX}
- done_o  out  1  one-cycle result-valid pulse
- result_o  out  WIDTH  result; held from done until the next accepted start

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, result_o=0, done_o=0, iteration counter=0, operand registers=0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 with op_i=MU_NOP → DONE, result_o=0.
  - start_i=1 with a special case (see below) → DONE.
  - Otherwise start_i=1 → CALC, counter=0. Capture op, the absolute values of the operands per op signedness, and the result-negate flag.
- CALC: one iteration per cycle.
  - Multiply: 2*WIDTH-bit accumulator, shift-add.
  - Divide: restoring; shift partial remainder in, subtract divisor, set quotient bit if no borrow.
  - After WIDTH cycles (counter reaches WIDTH-1) → FIX.
- FIX: select and sign-fix the result, register into result_o, → DONE.
  - MUL: low word.
  - MULH/MULHU/MULHSU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Negate product if operand signs differ (MULH: both signed; MULHSU: a signed, b unsigned; MUL computed signed, low word unaffected).
  - Quotient negated if signs differ (DIV only); remainder takes dividend sign (REM only).
- DONE: done_o=1 for exactly this cycle; → IDLE unconditionally. A start_i in DONE is ignored (ready_o=0).
- Latency:
  - Start sampled at edge ending cycle N → done_o high in cycle N+WIDTH+2 (34 for WIDTH=32).
  - Fast path (NOP, divide-by-zero, overflow): done_o in cycle N+1.
- Special cases, resolved in IDLE without entering CALC:
  - DIV/DIVU by zero: quotient all ones.
  - REM/REMU by zero: result = a_i.
  - DIV with a_i=0x8000_0000, b_i=0xFFFF_FFFF: result 0x8000_0000; REM of the same operands: 0.
- start_i while not IDLE: ignored; no queuing.
- Flush:
  - flush_i=1 in any state → IDLE at the next edge. No done_o, result_o unchanged.
  - flush_i has priority over start_i in the same cycle.
  - flush_i during DONE still allows the done pulse already asserted that cycle.
- Operands are registered on accept; a_i/b_i/op_i may change freely while busy.
- Reset asserted mid-operation: immediate return to reset values; no done.

Decomposition:
- Shared package additions:
  - mu_seq_state_t enum {MU_SEQ_IDLE, MU_SEQ_CALC, MU_SEQ_FIX, MU_SEQ_DONE}.
  - MU_ITERS = XLEN.
  - Helper predicates is_mu_div(op), is_mu_signed_a(op), is_mu_signed_b(op) as package functions.
- Sub-module cotm32_mu_iter: purely combinational single-step datapath (shift-add step or restoring subtract step selected by an is_div input). The sequencer owns all registers and the FSM.

Test Plan:
1. MUL a=7, b=0xFFFF_FFFD (-3): start in cycle N → done_o only in cycle N+34, result 0xFFFF_FFEB; ready_o=0 in N+1..N+34.
2. High products:
   - MULH 0x8000_0000×0x8000_0000 → 0x4000_0000.
   - MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE.
   - MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF → 0xFFFF_FFFF.
3. Divides:
   - DIV -7/2 → 0xFFFF_FFFD; REM -7/2 → 0xFFFF_FFFF.
   - DIVU 100/7 → 14; REMU 100/7 → 2.
4. Special cases:
   - DIV 5/0 → 0xFFFF_FFFF with done in N+1; REM 5/0 → 5 in N+1.
   - DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM of the same operands → 0, both in N+1.
5. Flush and ignored start:
   - start DIVU, flush_i in cycle N+10 → no done_o ever, ready_o=1 in N+11, result_o keeps its prior value.
   - start_i pulsed in N+5 while busy → ignored, original op completes unchanged.
6. Reset and NOP:
   - Drop rst_n asynchronously mid-CALC → outputs return to reset values without waiting for a clock edge; no done after release.
   - MU_NOP start → done in N+1, result 0.
